// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU write-back path: instruction
// write-back classes, sequencer states and register-file constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    WB_ALU_R = 2'b00,
    WB_ALU_I = 2'b01,
    WB_LOAD  = 2'b10,
    WB_NOWB  = 2'b11
  } wb_class_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_WRITE    = 2'b10
  } wb_state_e;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/wb_timeout_cnt.sv
// MEM_WAIT cycle counter: clears while not waiting, counts waiting cycles and
// flags the cycle that is the TIMEOUT_CYC-th one spent waiting.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Current cycle completes the TIMEOUT_CYC-th wait cycle.
  assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer for the multicycle CPU: drives MemToReg/RegWrite/write_reg.
// Optional MEM_WAIT abort timer enabled by defining WB_TIMEOUT_EN.
module wb_sequencer
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            wb_class,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_ready,
  input  logic                  flush,
  output logic                  MemToReg,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  regwrite_q, regwrite_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  terr_q, terr_d;
  logic                  tmo_hit;
  wb_class_e             cls;

  assign cls = wb_class_e'(wb_class);

`ifdef WB_TIMEOUT_EN
  logic waiting;
  assign waiting = (state_q == ST_MEM_WAIT);

  wb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(!waiting),
    .en_i (waiting),
    .tc_o (tmo_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    write_reg_d = write_reg_q;
    memtoreg_d  = memtoreg_q;
    regwrite_d  = 1'b0;
    done_d      = 1'b0;
    terr_d      = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          write_reg_d = (cls == WB_ALU_R) ? rd : rt;
          if (cls == WB_LOAD) begin
            state_d = ST_MEM_WAIT;
          end else begin
            state_d    = ST_WRITE;
            memtoreg_d = 1'b0;
            done_d     = 1'b0 | 1'b1;
            regwrite_d = (cls != WB_NOWB) &&
                         (write_reg_d != REG_ADDR_W'(REG_ZERO));
          end
        end
      end
      ST_MEM_WAIT: begin
        // flush beats mem_ready; mem_ready beats the timeout.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          state_d    = ST_WRITE;
          memtoreg_d = 1'b1;
          done_d     = 1'b1;
          regwrite_d = (write_reg_q != REG_ADDR_W'(REG_ZERO));
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          terr_d  = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      write_reg_q <= '0;
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_reg_q <= write_reg_d;
      memtoreg_q  <= memtoreg_d;
      regwrite_q  <= regwrite_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  assign MemToReg    = memtoreg_q;
  assign RegWrite    = regwrite_q;
  assign write_reg   = write_reg_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule
